// File: rtl/hynoc_stream_gen_if.sv
// rtl/hynoc_stream_gen_if.sv - ingress write port bundle for the HyNoC stream generator
//
// Purpose: carries the flit write path between the generator and an ingress FIFO.
// Signals:
//   write      - flit write strobe          (master -> slave)
//   data       - flit value, MSB = close    (master -> slave)
//   fifo_level - ingress FIFO occupancy      (slave -> master)
interface hynoc_stream_gen_if #(
  parameter int FLIT_WIDTH      = 33,
  parameter int LOG2_FIFO_DEPTH = 5
);
  logic                     write;
  logic [FLIT_WIDTH-1:0]    data;
  logic [LOG2_FIFO_DEPTH:0] fifo_level;

  modport master (output write, output data, input fifo_level);
  modport slave  (input write, input data, output fifo_level);
endinterface

// File: rtl/hynoc_stream_gen.sv
// rtl/hynoc_stream_gen.sv - deterministic multi-destination packet generator for HyNoC ingress
//
// Purpose: on a start pulse, emits nb_packets packets (address flits, ID flit,
// payload flits, close flit), rotating destinations over the enabled channels.
// Ports:
//   i_local_clk / i_local_srst     - clock, synchronous active-high reset
//   i_start / i_stop               - run start pulse, end-of-run request (level)
//   i_nb_packets .. i_lfsr_seed    - run configuration, latched at start
//   i_channel_enable               - destination mask, sampled at each packet start
//   i_address_flits                - per-channel address flits
//   o_busy / o_done / o_packet_sent / o_packet_channel / o_packets_sent - status
//   io_ingress                     - flit write port (write, data, fifo_level)
module hynoc_stream_gen #(
  parameter int NB_CHANNELS      = 4,
  parameter int NB_ADDRESS_FLITS = 1,
  parameter int PAYLOAD_WIDTH    = 32,
  parameter int FLIT_WIDTH       = PAYLOAD_WIDTH + 1,
  parameter int LOG2_FIFO_DEPTH  = 5,
  parameter int FIFO_MARGIN      = 1,
  parameter int LEN_WIDTH        = 16,
  parameter int WRITER_ID        = 0
) (
  input  logic                                              i_local_clk,
  input  logic                                              i_local_srst,
  input  logic                                              i_start,
  input  logic                                              i_stop,
  input  logic [15:0]                                       i_nb_packets,
  input  logic [LEN_WIDTH-1:0]                              i_packet_len,
  input  logic [15:0]                                       i_gap_cycles,
  input  logic [1:0]                                        i_payload_mode,
  input  logic [31:0]                                       i_lfsr_seed,
  input  logic [NB_CHANNELS-1:0]                            i_channel_enable,
  input  logic [NB_CHANNELS*NB_ADDRESS_FLITS*FLIT_WIDTH-1:0] i_address_flits,
  output logic                                              o_busy,
  output logic                                              o_done,
  output logic                                              o_packet_sent,
  output logic [2:0]                                        o_packet_channel,
  output logic [15:0]                                       o_packets_sent,
  hynoc_stream_gen_if.master                                io_ingress
);
  localparam int HALF = PAYLOAD_WIDTH / 2;
  localparam logic [LOG2_FIFO_DEPTH:0] ROOM_LIMIT =
    (LOG2_FIFO_DEPTH+1)'((1 << LOG2_FIFO_DEPTH) - FIFO_MARGIN);
  localparam logic [HALF-1:0] WID = HALF'(WRITER_ID);
  // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [2:0] {
    S_IDLE, S_GAP, S_ADDR, S_ID, S_PAYLOAD, S_CLOSE, S_DONE
  } state_t;

  state_t                  r_state;
  logic                    r_busy, r_done, r_packet_sent, r_write, r_first, r_stop_req;
  logic [2:0]              r_chan;
  logic [15:0]             r_packets_sent, r_nb, r_gap, r_gap_cnt;
  logic [LEN_WIDTH-1:0]    r_len;
  logic [1:0]              r_mode;
  logic [31:0]             r_seed, r_lfsr, r_cnt;
  logic [HALF-1:0]         r_pkt_id;
  logic [FLIT_WIDTH-1:0]   r_data;

  logic                    w_room, w_found;
  logic [2:0]              w_next_chan;
  logic [31:0]             w_lfsr_next;
  logic [PAYLOAD_WIDTH-1:0] w_payload;
  logic [FLIT_WIDTH-1:0]   w_addr_flit;

  // Same-cycle level only; FIFO_MARGIN absorbs the FIFO's level update latency.
  assign w_room      = io_ingress.fifo_level < ROOM_LIMIT;
  assign w_lfsr_next = {1'b0, r_lfsr[31:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 32'h0);
  assign w_addr_flit = i_address_flits[(int'(r_chan) * NB_ADDRESS_FLITS + int'(r_cnt)) * FLIT_WIDTH +: FLIT_WIDTH];

  // The LFSR payload is the post-step state, so the first flit is one step past the seed.
  always_comb begin
    w_payload = PAYLOAD_WIDTH'(r_cnt);
    case (r_mode)
      2'd1:    w_payload = w_lfsr_next[PAYLOAD_WIDTH-1:0];
      2'd2:    w_payload = r_seed[PAYLOAD_WIDTH-1:0];
      default: w_payload = PAYLOAD_WIDTH'(r_cnt);
    endcase
  end

  // Round-robin: scan upward from the channel after the previous one, wrapping.
  always_comb begin
    int c;
    w_found     = 1'b0;
    w_next_chan = '0;
    c           = 0;
    for (int k = 0; k < NB_CHANNELS; k++) begin
      c = (r_first ? k : int'(r_chan) + 1 + k) % NB_CHANNELS;
      if (!w_found && i_channel_enable[c]) begin
        w_found     = 1'b1;
        w_next_chan = 3'(c);
      end
    end
  end

  always_ff @(posedge i_local_clk) begin
    if (i_local_srst) begin
      r_state        <= S_IDLE;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_packet_sent  <= 1'b0;
      r_write        <= 1'b0;
      r_data         <= '0;
      r_first        <= 1'b1;
      r_stop_req     <= 1'b0;
      r_chan         <= '0;
      r_packets_sent <= '0;
      r_nb           <= '0;
      r_gap          <= '0;
      r_gap_cnt      <= '0;
      r_len          <= '0;
      r_mode         <= '0;
      r_seed         <= '0;
      r_lfsr         <= 32'd1;
      r_cnt          <= '0;
      r_pkt_id       <= '0;
    end else begin
      r_done        <= 1'b0;
      r_packet_sent <= 1'b0;
      r_write       <= 1'b0;
      // A stop seen mid-packet is remembered so the run ends at the next close.
      if (i_stop && r_busy) r_stop_req <= 1'b1;
      case (r_state)
        S_IDLE: if (i_start) begin
          r_nb           <= i_nb_packets;
          r_len          <= (i_packet_len == '0) ? LEN_WIDTH'(1) : i_packet_len;
          r_gap          <= i_gap_cycles;
          r_gap_cnt      <= i_gap_cycles;
          r_mode         <= i_payload_mode;
          r_seed         <= i_lfsr_seed;
          r_lfsr         <= (i_lfsr_seed == 32'd0) ? 32'd1 : i_lfsr_seed;
          r_packets_sent <= '0;
          r_pkt_id       <= '0;
          r_first        <= 1'b1;
          r_stop_req     <= 1'b0;
          r_busy         <= 1'b1;
          r_state        <= (i_nb_packets == 16'd0 || i_stop) ? S_DONE : S_GAP;
        end
        S_GAP: begin
          if (i_stop || r_stop_req) begin
            r_state <= S_DONE;
          end else if (r_gap_cnt != 16'd0) begin
            r_gap_cnt <= r_gap_cnt - 16'd1;
          end else if (w_found) begin
            r_chan  <= w_next_chan;
            r_first <= 1'b0;
            r_cnt   <= '0;
            r_state <= S_ADDR;
          end
        end
        S_ADDR: if (w_room) begin
          r_write <= 1'b1;
          r_data  <= w_addr_flit;
          if (r_cnt == 32'(NB_ADDRESS_FLITS - 1)) begin
            r_cnt   <= '0;
            r_state <= S_ID;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_ID: if (w_room) begin
          r_write <= 1'b1;
          r_data  <= {1'b0, WID, r_pkt_id};
          r_cnt   <= '0;
          r_state <= S_PAYLOAD;
        end
        S_PAYLOAD: if (w_room) begin
          r_write <= 1'b1;
          r_data  <= {1'b0, w_payload};
          if (r_mode == 2'd1) r_lfsr <= w_lfsr_next;
          if (r_cnt == 32'(r_len - LEN_WIDTH'(1))) begin
            r_state <= S_CLOSE;
          end else begin
            r_cnt <= r_cnt + 32'd1;
          end
        end
        S_CLOSE: if (w_room) begin
          r_write        <= 1'b1;
          r_data         <= {1'b1, WID, r_pkt_id};
          r_packet_sent  <= 1'b1;
          r_packets_sent <= r_packets_sent + 16'd1;
          r_pkt_id       <= r_pkt_id + HALF'(1);
          r_gap_cnt      <= r_gap;
          if (r_packets_sent + 16'd1 == r_nb || r_stop_req || i_stop) r_state <= S_DONE;
          else                                                         r_state <= S_GAP;
        end
        S_DONE: begin
          r_done     <= 1'b1;
          r_busy     <= 1'b0;
          r_stop_req <= 1'b0;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy           = r_busy;
  assign o_done           = r_done;
  assign o_packet_sent    = r_packet_sent;
  assign o_packet_channel = r_chan;
  assign o_packets_sent   = r_packets_sent;
  assign io_ingress.write = r_write;
  assign io_ingress.data  = r_data;
endmodule

// File: tb/tb_hynoc_stream_gen.sv
// tb/tb_hynoc_stream_gen.sv - scoreboard bench for hynoc_stream_gen
module tb_hynoc_stream_gen;
  localparam int NB  = 4;
  localparam int NA  = 1;
  localparam int PW  = 32;
  localparam int FW  = PW + 1;
  localparam int L2  = 5;
  localparam int LW  = 16;
  localparam logic [15:0] WID = 16'hA5C3;

  typedef struct { logic [FW-1:0] flit; bit close; } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic i_start, i_stop;
  logic [15:0] i_nb_packets, i_gap_cycles;
  logic [LW-1:0] i_packet_len;
  logic [1:0] i_payload_mode;
  logic [31:0] i_lfsr_seed;
  logic [NB-1:0] i_channel_enable;
  logic [NB*NA*FW-1:0] addr_flits;
  logic o_busy, o_done, o_packet_sent;
  logic [2:0] o_packet_channel;
  logic [15:0] o_packets_sent;

  hynoc_stream_gen_if #(.FLIT_WIDTH(FW), .LOG2_FIFO_DEPTH(L2)) ingress();

  hynoc_stream_gen #(
    .NB_CHANNELS(NB), .NB_ADDRESS_FLITS(NA), .PAYLOAD_WIDTH(PW), .FLIT_WIDTH(FW),
    .LOG2_FIFO_DEPTH(L2), .FIFO_MARGIN(1), .LEN_WIDTH(LW), .WRITER_ID(int'(WID))
  ) dut (
    .i_local_clk(clk), .i_local_srst(rst), .i_start(i_start), .i_stop(i_stop),
    .i_nb_packets(i_nb_packets), .i_packet_len(i_packet_len), .i_gap_cycles(i_gap_cycles),
    .i_payload_mode(i_payload_mode), .i_lfsr_seed(i_lfsr_seed),
    .i_channel_enable(i_channel_enable), .i_address_flits(addr_flits),
    .o_busy(o_busy), .o_done(o_done), .o_packet_sent(o_packet_sent),
    .o_packet_channel(o_packet_channel), .o_packets_sent(o_packets_sent),
    .io_ingress(ingress.master)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  exp_t exp_q[$];
  int chan_q[$];

  // run configuration
  int c_nb, c_exp, c_len, c_gap, c_mode, c_late_from;
  int c_q_kind, c_q_from, c_q_to, c_stop_at, c_rst_at;
  logic [31:0] c_seed;
  logic [NB-1:0] c_en, c_en_late;
  bit c_timing, c_rbp;

  task automatic check(input bit ok, input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // Galois LFSR defined by its polynomial exponents: term x^e toggles bit e-1.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    int exps[4];
    logic [31:0] mask;
    exps = '{32, 22, 2, 1};
    mask = '0;
    foreach (exps[i]) mask[exps[i]-1] = 1'b1;
    return s[0] ? ((s >> 1) ^ mask) : (s >> 1);
  endfunction

  function automatic int next_chan(input int prev, input bit first, input logic [NB-1:0] en);
    int base;
    base = first ? 0 : prev + 1;
    for (int k = 0; k < NB; k++)
      if (en[(base + k) % NB]) return (base + k) % NB;
    return -1;
  endfunction

  task automatic push_model();
    logic [31:0] lf;
    logic [PW-1:0] v;
    int prev, ch, l;
    exp_t x;
    lf = (c_seed == 0) ? 32'd1 : c_seed;
    l = (c_len == 0) ? 1 : c_len;
    prev = 0;
    for (int p = 0; p < c_exp; p++) begin
      ch = next_chan(prev, p == 0, (p >= c_late_from) ? c_en_late : c_en);
      prev = ch;
      chan_q.push_back(ch);
      for (int a = 0; a < NA; a++) begin
        x.flit = addr_flits[(ch*NA + a)*FW +: FW]; x.close = 0; exp_q.push_back(x);
      end
      x.flit = {1'b0, WID, 16'(p)}; x.close = 0; exp_q.push_back(x);
      for (int i = 0; i < l; i++) begin
        case (c_mode)
          1: begin lf = lfsr_step(lf); v = lf[PW-1:0]; end
          2: v = c_seed[PW-1:0];
          default: v = PW'(i);
        endcase
        x.flit = {1'b0, v}; x.close = 0; exp_q.push_back(x);
      end
      x.flit = {1'b1, WID, 16'(p)}; x.close = 1; exp_q.push_back(x);
    end
  endtask

  // monitor: pops one expected flit per observed write
  always @(negedge clk) begin
    exp_t e;
    int ch;
    if (!rst) begin
      if (ingress.write) begin
        if (exp_q.size() == 0) begin
          check(1'b0, "unexpected_write", 64'(ingress.data), 64'd0);
        end else begin
          e = exp_q.pop_front();
          check(ingress.data === e.flit, "flit_data", 64'(ingress.data), 64'(e.flit));
          check(o_packet_sent === e.close, "packet_sent_on_close", 64'(o_packet_sent), 64'(e.close));
        end
      end else if (o_packet_sent) begin
        check(1'b0, "packet_sent_without_write", 64'(o_packet_sent), 64'd0);
      end
      if (o_packet_sent && chan_q.size() != 0) begin
        ch = chan_q.pop_front();
        check(o_packet_channel == 3'(ch), "packet_channel", 64'(o_packet_channel), 64'(ch));
      end
    end
  end

  task automatic set_defaults();
    c_nb = 1; c_exp = 1; c_len = 3; c_gap = 0; c_mode = 0; c_seed = 32'd1;
    c_en = '1; c_en_late = '1; c_late_from = 1000;
    c_q_kind = 0; c_q_from = -1; c_q_to = -1; c_stop_at = -1; c_rst_at = -1;
    c_timing = 1; c_rbp = 0;
  endtask

  task automatic do_run();
    int k, first_w, quiet_w, per, l, exp_done;
    bit got_done;
    for (int i = 0; i < NB*NA; i++) addr_flits[i*FW +: FW] = FW'({$urandom(), $urandom()});
    if (c_late_from >= c_exp) c_en_late = c_en;
    push_model();
    i_nb_packets = 16'(c_nb); i_packet_len = LW'(c_len); i_gap_cycles = 16'(c_gap);
    i_payload_mode = 2'(c_mode); i_lfsr_seed = c_seed; i_channel_enable = c_en;
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    check(o_busy === 1'b1, "busy_after_start", 64'(o_busy), 64'd1);
    k = 0; first_w = -1; quiet_w = 0; got_done = 0;
    while (k < 5000 && !got_done) begin
      if (k == c_q_from && c_q_kind == 1) ingress.fifo_level = 6'd31;
      if (k == c_q_to   && c_q_kind == 1) ingress.fifo_level = 6'd0;
      if (k == c_q_from && c_q_kind == 2) i_channel_enable = '0;
      if (k == c_q_to   && c_q_kind == 2) i_channel_enable = c_en_late;
      if (c_rbp) ingress.fifo_level = ($urandom_range(0, 2) == 0) ? 6'd31 : 6'($urandom_range(0, 30));
      i_stop = (k == c_stop_at);
      if (k == c_rst_at) begin
        rst = 1'b1;
        @(posedge clk); #1;
        check(ingress.write === 1'b0, "reset_drops_write", 64'(ingress.write), 64'd0);
        check(o_busy === 1'b0, "reset_drops_busy", 64'(o_busy), 64'd0);
        exp_q.delete(); chan_q.delete();
        rst = 1'b0;
        return;
      end
      @(posedge clk); #1;
      k++;
      if (ingress.write && first_w < 0) first_w = k;
      if (ingress.write && k > c_q_from && k <= c_q_to) quiet_w++;
      if (o_done) got_done = 1;
    end
    i_stop = 1'b0;
    ingress.fifo_level = '0;
    check(got_done, "done_within_budget", 64'(k), 64'd5000);
    if (!got_done) begin
      rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
      exp_q.delete(); chan_q.delete();
      return;
    end
    check(o_busy === 1'b0, "busy_low_at_done", 64'(o_busy), 64'd0);
    check(o_packets_sent == 16'(c_exp), "packets_sent", 64'(o_packets_sent), 64'(c_exp));
    if (c_q_kind != 0)
      check(quiet_w == 0, "no_write_in_quiet_window", 64'(quiet_w), 64'd0);
    if (c_timing) begin
      l = (c_len == 0) ? 1 : c_len;
      per = NA + l + 2 + c_gap + 1;
      exp_done = c_exp * per + 1 + ((c_q_kind == 1) ? (c_q_to - c_q_from) : 0);
      check(k == exp_done, "done_cycle", 64'(k), 64'(exp_done));
      check(first_w == ((c_exp > 0) ? c_gap + 2 : -1), "first_write_cycle",
            64'(first_w), 64'((c_exp > 0) ? c_gap + 2 : -1));
    end
    @(posedge clk); #1;
    check(o_done === 1'b0, "done_single_pulse", 64'(o_done), 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check(exp_q.size() == 0, "flit_queue_drained", 64'(exp_q.size()), 64'd0);
    check(chan_q.size() == 0, "chan_queue_drained", 64'(chan_q.size()), 64'd0);
  endtask

  initial begin
    rst = 1'b1; i_start = 1'b0; i_stop = 1'b0;
    i_nb_packets = '0; i_packet_len = '0; i_gap_cycles = '0; i_payload_mode = '0;
    i_lfsr_seed = '0; i_channel_enable = '0; addr_flits = '0; ingress.fifo_level = '0;
    repeat (3) @(posedge clk);
    #1;
    check(o_busy === 1'b0, "rst_busy", 64'(o_busy), 64'd0);
    check(o_done === 1'b0, "rst_done", 64'(o_done), 64'd0);
    check(o_packet_sent === 1'b0, "rst_packet_sent", 64'(o_packet_sent), 64'd0);
    check(o_packets_sent === 16'd0, "rst_packets_sent", 64'(o_packets_sent), 64'd0);
    check(o_packet_channel === 3'd0, "rst_packet_channel", 64'(o_packet_channel), 64'd0);
    check(ingress.write === 1'b0, "rst_write", 64'(ingress.write), 64'd0);
    check(ingress.data === '0, "rst_data", 64'(ingress.data), 64'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    // all channels, 8 packets, back-to-back
    set_defaults(); c_nb = 8; c_exp = 8; c_len = 3; c_en = 4'b1111;
    do_run();

    // sparse enable, then a stall in GAP with no channel, resuming on channel 3
    set_defaults(); c_nb = 4; c_exp = 4; c_len = 2; c_gap = 12; c_en = 4'b0101;
    c_en_late = 4'b1000; c_late_from = 2; c_q_kind = 2; c_q_from = 37; c_q_to = 80; c_timing = 0;
    do_run();

    // LFSR payload across two packets, then seed 0 behaving as seed 1
    set_defaults(); c_nb = 2; c_exp = 2; c_len = 4; c_mode = 1; c_seed = 32'd1;
    do_run();
    set_defaults(); c_nb = 2; c_exp = 2; c_len = 4; c_mode = 1; c_seed = 32'd0;
    do_run();

    // FIFO full for 5 cycles during payload flit 2
    set_defaults(); c_nb = 1; c_exp = 1; c_len = 4; c_q_kind = 1; c_q_from = 5; c_q_to = 10;
    do_run();

    // stop during payload of packet 2 of 10
    set_defaults(); c_nb = 10; c_exp = 2; c_len = 5; c_stop_at = 13;
    do_run();

    // zero packets
    set_defaults(); c_nb = 0; c_exp = 0;
    do_run();

    // constant payload mode and zero length
    set_defaults(); c_nb = 3; c_exp = 3; c_len = 0; c_mode = 2; c_seed = 32'hDEAD_BEEF; c_gap = 2;
    do_run();

    // reset mid-payload, then a fresh run must restart id and LFSR
    set_defaults(); c_nb = 3; c_exp = 3; c_len = 8; c_mode = 1; c_seed = $urandom(); c_rst_at = 6;
    do_run();
    @(posedge clk); #1;
    set_defaults(); c_nb = 2; c_exp = 2; c_len = 3; c_mode = 1; c_seed = $urandom();
    do_run();

    // randomized runs with random backpressure
    for (int r = 0; r < 6; r++) begin
      set_defaults();
      c_nb = $urandom_range(1, 5); c_exp = c_nb; c_len = $urandom_range(0, 6);
      c_gap = $urandom_range(0, 3); c_mode = $urandom_range(0, 3);
      c_seed = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom();
      c_en = NB'($urandom_range(1, (1 << NB) - 1));
      c_timing = 0; c_rbp = 1;
      do_run();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
